// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, redirect handling and the IF/ID
// pipeline register. Stall has priority over jump, jump over branch, and
// branch over sequential fetch. Every redirect costs exactly one bubble.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign_err
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_target;

    // Sequential successor and the selected redirect target (jump wins over branch)
    always_comb begin
        pc_plus4        = pc + 32'd4;
        redirect        = jump | Branch;
        redirect_target = jump ? jump_target : branch_target;
    end

    // PC, IF/ID register, sticky misalignment flag and BOOT/RUN state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
            if_id_instr  <= NOP_INSTR;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    pc          <= RESET_PC;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                    state       <= RUN;
                end
                default: begin
                    if (stall) begin
                        pc <= pc;
                    end else if (redirect) begin
                        pc          <= {redirect_target[31:2], 2'b00};
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc_plus4;
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                        if (redirect_target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                        end
                    end else begin
                        pc          <= pc_plus4;
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc_plus4;
                        if_id_instr <= imem_rdata;
                        if_id_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a reference model computes the
// expected state for each edge, queues it, and compares after the edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        Branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] instr;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic        m_boot;
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
    logic        m_valid, m_err;

    if_fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .Branch        (Branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: address 0 returns 32'h93, every word is distinct
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a << 8) | 32'h0000_0093;
    endfunction

    assign imem_rdata = imem(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = RST_PC;
        m_ifpc  = '0;
        m_ifpc4 = '0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check("rst_pc",    imem_addr,          RST_PC);
        check("rst_ifpc",  if_id_pc,           32'h0);
        check("rst_ifpc4", if_id_pc4,          32'h0);
        check("rst_instr", if_id_instr,        NOP);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_err",   {31'h0, misalign_err}, 32'h0);
    endtask

    // Drive one cycle of inputs, predict the edge, then compare after it
    task automatic step(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        logic [31:0] t;
        exp_t e;
        stall = s; Branch = b; branch_target = bt; jump = j; jump_target = jt;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (s) begin
            // hold everything
        end else if (j || b) begin
            t = j ? jt : bt;
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_instr = NOP;
            m_valid = 1'b0;
            if (t[1:0] != 2'b00) m_err = 1'b1;
            m_pc = {t[31:2], 2'b00};
        end else begin
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_instr = imem(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        exp_q.push_back('{m_pc, m_ifpc, m_ifpc4, m_instr, m_valid, m_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pc",    imem_addr,   e.pc);
        check("ifpc",  if_id_pc,    e.ifpc);
        check("ifpc4", if_id_pc4,   e.ifpc4);
        check("instr", if_id_instr, e.instr);
        check("valid", {31'h0, if_id_valid},  {31'h0, e.valid});
        check("err",   {31'h0, misalign_err}, {31'h0, e.err});
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset pulse taken in the middle of a cycle
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; Branch = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Boot edge then first real fetch from address 0
        seq(1);
        check("boot_valid", {31'h0, if_id_valid}, 32'h0);
        seq(1);
        check("first_instr", if_id_instr, 32'h0000_0093);
        check("first_addr",  imem_addr,   32'h4);

        // Advance to PC=0x10, branch to 0x40
        seq(3);
        check("at_10", imem_addr, 32'h10);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("br_pc", imem_addr, 32'h40);
        seq(1);
        check("br_tgt_ifpc", if_id_pc, 32'h40);

        // Reach PC=0x20, stall 3 cycles with Branch asserted, then release
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        seq(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h60, 1'b0, 32'h0);
        check("stall_pc", imem_addr, 32'h24);
        step(1'b0, 1'b1, 32'h60, 1'b0, 32'h0);
        check("post_stall_pc", imem_addr, 32'h60);

        // jump and branch together: jump wins
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        check("jump_prio", imem_addr, 32'h80);
        seq(1);

        // Misaligned branch target sets a sticky flag
        step(1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
        check("mis_pc", imem_addr, 32'h40);
        seq(10);
        check("mis_sticky", {31'h0, misalign_err}, 32'h1);
        reset_pulse();
        seq(2);

        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        seq(1);
        check("wrap_pc",    imem_addr, 32'h0);
        check("wrap_ifpc4", if_id_pc4, 32'h0);

        // Reset in the middle of a stall with a pending redirect
        seq(2);
        step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        stall = 1'b1; Branch = 1'b1; branch_target = 32'h100;
        reset_pulse();
        step(1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        check("boot_again_pc", imem_addr, RST_PC);
        seq(2);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom_range(0, 255) << 2;
            jt = $urandom_range(0, 255) << 2;
            if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), bt,
                 ($urandom_range(0, 6) == 0), jt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
